// File: rtl/tone_detector.sv
// tone_detector
//   Measures an asynchronous square wave in clk cycles. The input is
//   synchronised, glitch-filtered and edge-detected. The block then reports
//   the period and high time between consecutive filtered rising edges.
//
// Parameters
//   CNT_WIDTH      width of the period/high-time counters and outputs
//   GLITCH_CYCLES  consecutive differing samples needed before the filtered
//                  level follows the input (1..255)
//
// Ports
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   enable       measurement enable; low returns the FSM to WAIT_EDGE
//   square_in    asynchronous square-wave input
//   period       cycles between the last two filtered rising edges
//   high_time    cycles the filtered level was high within that period
//   meas_valid   one-cycle pulse when period/high_time update
//   locked       a complete period has been measured since the last lock loss
//   signal_lost  sticky timeout flag, cleared by the next meas_valid
module tone_detector #(
  parameter int unsigned CNT_WIDTH     = 24,
  parameter int unsigned GLITCH_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic                 square_in,
  output logic [CNT_WIDTH-1:0] period,
  output logic [CNT_WIDTH-1:0] high_time,
  output logic                 meas_valid,
  output logic                 locked,
  output logic                 signal_lost
);

  typedef enum logic {
    WAIT_EDGE = 1'b0,
    MEASURE   = 1'b1
  } state_e;

  localparam logic [7:0]           GLITCH_LIM = GLITCH_CYCLES[7:0];
  localparam logic [CNT_WIDTH-1:0] CNT_MAX    = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE    = CNT_WIDTH'(1);

  state_e               state_q, state_d;
  logic                 s1_q, s2_q;
  logic                 filt_q, filt_d;
  logic                 filt_dly_q;
  logic [7:0]           glitch_cnt_q, glitch_cnt_d;
  logic [CNT_WIDTH-1:0] period_cnt_q, period_cnt_d;
  logic [CNT_WIDTH-1:0] high_cnt_q, high_cnt_d;
  logic [CNT_WIDTH-1:0] period_q, period_d;
  logic [CNT_WIDTH-1:0] high_time_q, high_time_d;
  logic                 meas_valid_q, meas_valid_d;
  logic                 locked_q, locked_d;
  logic                 signal_lost_q, signal_lost_d;
  logic                 rise;

  // Glitch filter: the level changes on the same edge the stability count
  // would reach GLITCH_CYCLES, giving a fixed 2+GLITCH_CYCLES pin-to-filt delay.
  always_comb begin
    filt_d       = filt_q;
    glitch_cnt_d = '0;
    if (s2_q != filt_q) begin
      if (glitch_cnt_q + 8'd1 == GLITCH_LIM) begin
        filt_d = s2_q;
      end else begin
        glitch_cnt_d = glitch_cnt_q + 8'd1;
      end
    end
  end

  assign rise = filt_q & ~filt_dly_q;

  always_comb begin
    state_d       = state_q;
    period_cnt_d  = period_cnt_q;
    high_cnt_d    = high_cnt_q;
    period_d      = period_q;
    high_time_d   = high_time_q;
    meas_valid_d  = 1'b0;
    locked_d      = locked_q;
    signal_lost_d = signal_lost_q;
    unique case (state_q)
      WAIT_EDGE: begin
        period_cnt_d = '0;
        high_cnt_d   = '0;
        if (enable && rise) begin
          period_cnt_d = CNT_ONE;
          high_cnt_d   = CNT_ONE;
          state_d      = MEASURE;
        end
      end
      MEASURE: begin
        if (!enable) begin
          state_d      = WAIT_EDGE;
          locked_d     = 1'b0;
          period_cnt_d = '0;
          high_cnt_d   = '0;
        end else if (rise) begin
          period_d      = period_cnt_q;
          high_time_d   = high_cnt_q;
          period_cnt_d  = CNT_ONE;
          high_cnt_d    = CNT_ONE;
          meas_valid_d  = 1'b1;
          locked_d      = 1'b1;
          signal_lost_d = 1'b0;
        end else if (period_cnt_q == CNT_MAX) begin
          state_d       = WAIT_EDGE;
          locked_d      = 1'b0;
          signal_lost_d = 1'b1;
          period_cnt_d  = '0;
          high_cnt_d    = '0;
        end else begin
          period_cnt_d = period_cnt_q + CNT_ONE;
          // The rise cycle already seeded the count with 1, so counting the
          // current filtered level here makes high_time equal the high phase.
          if (filt_q) begin
            high_cnt_d = high_cnt_q + CNT_ONE;
          end
        end
      end
      default: state_d = WAIT_EDGE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= WAIT_EDGE;
      s1_q          <= 1'b0;
      s2_q          <= 1'b0;
      filt_q        <= 1'b0;
      filt_dly_q    <= 1'b0;
      glitch_cnt_q  <= '0;
      period_cnt_q  <= '0;
      high_cnt_q    <= '0;
      period_q      <= '0;
      high_time_q   <= '0;
      meas_valid_q  <= 1'b0;
      locked_q      <= 1'b0;
      signal_lost_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      s1_q          <= square_in;
      s2_q          <= s1_q;
      filt_q        <= filt_d;
      filt_dly_q    <= filt_q;
      glitch_cnt_q  <= glitch_cnt_d;
      period_cnt_q  <= period_cnt_d;
      high_cnt_q    <= high_cnt_d;
      period_q      <= period_d;
      high_time_q   <= high_time_d;
      meas_valid_q  <= meas_valid_d;
      locked_q      <= locked_d;
      signal_lost_q <= signal_lost_d;
    end
  end

  assign period      = period_q;
  assign high_time   = high_time_q;
  assign meas_valid  = meas_valid_q;
  assign locked      = locked_q;
  assign signal_lost = signal_lost_q;

endmodule

// File: tb/tb_tone_detector.sv
// tb_tone_detector
//   Directed bench for tone_detector. A 24-bit instance covers the normal
//   measurements; a 12-bit instance on the same input covers the timeout.
module tb_tone_detector;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic        square_in;

  logic [23:0] period_a, high_a;
  logic        mv_a, locked_a, lost_a;
  logic [11:0] period_b, high_b;
  logic        mv_b, locked_b, lost_b;

  int unsigned total = 0;
  int unsigned bad   = 0;
  int unsigned mv_cnt_a = 0;
  int unsigned mv_cnt_b = 0;
  int unsigned base_a, base_b;

  always #5 clk = ~clk;

  tone_detector #(.CNT_WIDTH(24), .GLITCH_CYCLES(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .square_in(square_in),
    .period(period_a), .high_time(high_a), .meas_valid(mv_a),
    .locked(locked_a), .signal_lost(lost_a)
  );

  tone_detector #(.CNT_WIDTH(12), .GLITCH_CYCLES(4)) u_dut_small (
    .clk(clk), .rst_n(rst_n), .enable(enable), .square_in(square_in),
    .period(period_b), .high_time(high_b), .meas_valid(mv_b),
    .locked(locked_b), .signal_lost(lost_b)
  );

  // Count measurement pulses, sampled away from the active edge.
  always @(negedge clk) begin
    if (mv_a) mv_cnt_a = mv_cnt_a + 1;
    if (mv_b) mv_cnt_b = mv_cnt_b + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic hold(input logic lvl, input int unsigned n);
    square_in = lvl;
    repeat (n) @(negedge clk);
  endtask

  task automatic wave(input int unsigned p, input int unsigned h, input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      hold(1'b1, h);
      hold(1'b0, p - h);
    end
  endtask

  // Period 1000 / high 300 with a 3-cycle low glitch and a 2-cycle high glitch.
  task automatic glitch_wave(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      hold(1'b1, 100); hold(1'b0, 3); hold(1'b1, 197);
      hold(1'b0, 300); hold(1'b1, 2); hold(1'b0, 398);
    end
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b1; square_in = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_period",   32'(period_a), 32'd0);
    chk("rst_high",     32'(high_a),   32'd0);
    chk("rst_mv",       32'(mv_a),     32'd0);
    chk("rst_locked",   32'(locked_a), 32'd0);
    chk("rst_lost",     32'(lost_a),   32'd0);
    chk("rst_b_period", 32'(period_b), 32'd0);
    rst_n = 1'b1;
    hold(1'b0, 20);

    // Basic 1000/300 measurement; the first rise only arms.
    wave(1000, 300, 1);
    chk("first_no_mv",  mv_cnt_a,      32'd0);
    chk("first_unlock", 32'(locked_a), 32'd0);
    wave(1000, 300, 1);
    chk("second_mv",    mv_cnt_a,      32'd1);
    chk("second_per",   32'(period_a), 32'd1000);
    chk("second_high",  32'(high_a),   32'd300);
    chk("second_lock",  32'(locked_a), 32'd1);
    wave(1000, 300, 3);
    chk("run_mv",       mv_cnt_a,      32'd4);
    chk("run_per",      32'(period_a), 32'd1000);
    chk("run_high",     32'(high_a),   32'd300);
    chk("run_lost",     32'(lost_a),   32'd0);
    chk("b_per",        32'(period_b), 32'd1000);
    chk("b_high",       32'(high_b),   32'd300);

    // Odd-length 50 % wave: the high phase is the rounded-down half.
    base_a = mv_cnt_a;
    wave(4547, 2273, 1);
    chk("odd_prev_per", 32'(period_a), 32'd1000);
    for (int unsigned k = 0; k < 3; k++) begin
      wave(4547, 2273, 1);
      chk("odd_per",  32'(period_a), 32'd4547);
      chk("odd_high", 32'(high_a),   32'd2273);
    end
    chk("odd_mv", mv_cnt_a - base_a, 32'd4);

    // Glitches inside both phases change nothing.
    base_a = mv_cnt_a;
    glitch_wave(1);
    chk("gl_prev_per", 32'(period_a), 32'd4547);
    glitch_wave(3);
    chk("gl_per",  32'(period_a), 32'd1000);
    chk("gl_high", 32'(high_a),   32'd300);
    chk("gl_mv",   mv_cnt_a - base_a, 32'd4);

    // Timeout on the 12-bit instance after the input stops toggling.
    chk("b_lock_pre", 32'(locked_b), 32'd1);
    chk("b_lost_pre", 32'(lost_b),   32'd0);
    base_b = mv_cnt_b;
    hold(1'b0, 3000);
    chk("b_lock_wait", 32'(locked_b), 32'd1);
    hold(1'b0, 200);
    chk("b_to_lock",  32'(locked_b), 32'd0);
    chk("b_to_lost",  32'(lost_b),   32'd1);
    chk("b_to_per",   32'(period_b), 32'd1000);
    chk("b_to_high",  32'(high_b),   32'd300);
    chk("b_to_mv",    mv_cnt_b - base_b, 32'd0);
    chk("a_no_to",    32'(locked_a), 32'd1);
    wave(1000, 300, 1);
    chk("b_rs1_mv",   mv_cnt_b - base_b, 32'd0);
    chk("b_rs1_lost", 32'(lost_b),   32'd1);
    wave(1000, 300, 1);
    chk("b_rs2_mv",   mv_cnt_b - base_b, 32'd1);
    chk("b_rs2_lost", 32'(lost_b),   32'd0);
    chk("b_rs2_lock", 32'(locked_b), 32'd1);
    chk("b_rs2_per",  32'(period_b), 32'd1000);
    wave(1000, 300, 1);
    chk("a_rs_per",   32'(period_a), 32'd1000);

    // Enable dropped mid-period.
    hold(1'b1, 150);
    enable = 1'b0;
    @(negedge clk);
    chk("en_unlock", 32'(locked_a), 32'd0);
    base_a = mv_cnt_a;
    hold(1'b1, 149);
    hold(1'b0, 700);
    wave(1000, 300, 2);
    chk("en_off_mv", mv_cnt_a - base_a, 32'd0);
    enable = 1'b1;
    wave(1000, 300, 1);
    chk("en_arm_mv",   mv_cnt_a - base_a, 32'd0);
    chk("en_arm_lock", 32'(locked_a), 32'd0);
    wave(1000, 300, 1);
    chk("en_mv",   mv_cnt_a - base_a, 32'd1);
    chk("en_lock", 32'(locked_a), 32'd1);
    chk("en_per",  32'(period_a), 32'd1000);
    chk("en_high", 32'(high_a),   32'd300);

    // Reset asserted in the low phase of a running wave.
    hold(1'b1, 300);
    hold(1'b0, 300);
    rst_n = 1'b0;
    #1;
    chk("mr_per",    32'(period_a), 32'd0);
    chk("mr_high",   32'(high_a),   32'd0);
    chk("mr_lock",   32'(locked_a), 32'd0);
    chk("mr_lost",   32'(lost_a),   32'd0);
    chk("mr_b_lock", 32'(locked_b), 32'd0);
    base_a = mv_cnt_a;
    hold(1'b0, 20);
    rst_n = 1'b1;
    hold(1'b0, 380);
    wave(1000, 300, 1);
    chk("mr_arm_mv", mv_cnt_a - base_a, 32'd0);
    wave(1000, 300, 1);
    chk("mr_mv",   mv_cnt_a - base_a, 32'd1);
    chk("mr_per2", 32'(period_a), 32'd1000);
    chk("mr_high2", 32'(high_a),  32'd300);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
